axil_arbiter_2to1: RTL and testbench

Two-port AXI-Lite arbiter that shares one AXI-Lite slave (the UART-lite register file: RX FIFO at 0x0, TX FIFO at 0x4, status at 0x8) between two AXI-Lite masters, e.g. the UART polling master and a debug/config master. One complete transaction (write: AW+W+B, or read: AR+R) is granted at a time, with round-robin fairness between masters. Channels are routed combinationally while granted; arbitration costs one cycle per transaction.

---
 rtl/axil_arbiter_2to1.sv | 253 +++++++++++++++++++++++++
 tb/tb_axil_arbiter_2to1.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_arbiter_2to1.sv
// Two-master AXI-Lite arbiter: one whole transaction granted at a time, round-robin between masters.
// Optional hung-transaction abort is compiled in with `define ARB_TIMEOUT_EN (limit set by TOUT).
module axil_arbiter_2to1
`ifdef ARB_TIMEOUT_EN
  #(parameter int unsigned TOUT = 64)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  m0_awadr,
  input  logic        m0_awvld,
  output logic        m0_awrdy,
  input  logic [31:0] m0_wdat,
  input  logic        m0_wvld,
  output logic        m0_wrdy,
  output logic [1:0]  m0_bresp,
  output logic        m0_bvld,
  input  logic        m0_brdy,
  input  logic [3:0]  m0_aradr,
  input  logic        m0_arvld,
  output logic        m0_arrdy,
  output logic [31:0] m0_rdat,
  output logic        m0_rvld,
  input  logic        m0_rrdy,
  input  logic [3:0]  m1_awadr,
  input  logic        m1_awvld,
  output logic        m1_awrdy,
  input  logic [31:0] m1_wdat,
  input  logic        m1_wvld,
  output logic        m1_wrdy,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvld,
  input  logic        m1_brdy,
  input  logic [3:0]  m1_aradr,
  input  logic        m1_arvld,
  output logic        m1_arrdy,
  output logic [31:0] m1_rdat,
  output logic        m1_rvld,
  input  logic        m1_rrdy,
  output logic [3:0]  s_awadr,
  output logic        s_awvld,
  input  logic        s_awrdy,
  output logic [31:0] s_wdat,
  output logic        s_wvld,
  input  logic        s_wrdy,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvld,
  output logic        s_brdy,
  output logic [3:0]  s_aradr,
  output logic        s_arvld,
  input  logic        s_arrdy,
  input  logic [31:0] s_rdat,
  input  logic        s_rvld,
  output logic        s_rrdy,
  output logic [1:0]  gnt,
  output logic        tout_err
);

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RDATA
`ifdef ARB_TIMEOUT_EN
    , ERESP
`endif
  } state_t;

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic        r_last;
  logic        r_aw_done;
  logic        r_w_done;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]  r_cnt;
  logic        r_is_wr;
  logic        r_tout_err;
`endif

  logic        w_sel;
  logic        w_req0, w_req1, w_pick, w_pick_wr;
  logic [3:0]  w_awadr, w_aradr;
  logic [31:0] w_wdat;
  logic        w_awvld, w_wvld, w_brdy, w_arvld, w_rrdy;
  logic        w_aw_hs, w_w_hs, w_fin;
  logic        w_m_awrdy, w_m_wrdy, w_m_bvld, w_m_arrdy, w_m_rvld;
  logic [1:0]  w_m_bresp;
  logic [31:0] w_m_rdat;

  assign w_sel   = r_gnt[1];
  assign w_awadr = w_sel ? m1_awadr : m0_awadr;
  assign w_awvld = w_sel ? m1_awvld : m0_awvld;
  assign w_wdat  = w_sel ? m1_wdat  : m0_wdat;
  assign w_wvld  = w_sel ? m1_wvld  : m0_wvld;
  assign w_brdy  = w_sel ? m1_brdy  : m0_brdy;
  assign w_aradr = w_sel ? m1_aradr : m0_aradr;
  assign w_arvld = w_sel ? m1_arvld : m0_arvld;
  assign w_rrdy  = w_sel ? m1_rrdy  : m0_rrdy;

  // On a tie the master that was not served last wins; write beats read within a master.
  assign w_req0    = m0_awvld | m0_arvld;
  assign w_req1    = m1_awvld | m1_arvld;
  assign w_pick    = w_req1 & (~w_req0 | ~r_last);
  assign w_pick_wr = w_pick ? m1_awvld : m0_awvld;

  always_comb begin
    s_awadr   = '0;
    s_awvld   = 1'b0;
    s_wdat    = '0;
    s_wvld    = 1'b0;
    s_brdy    = 1'b0;
    s_aradr   = '0;
    s_arvld   = 1'b0;
    s_rrdy    = 1'b0;
    w_m_awrdy = 1'b0;
    w_m_wrdy  = 1'b0;
    w_m_bvld  = 1'b0;
    w_m_bresp = '0;
    w_m_arrdy = 1'b0;
    w_m_rvld  = 1'b0;
    w_m_rdat  = '0;
    case (r_state)
      WADDR: begin
        s_awadr   = w_awadr;
        s_awvld   = w_awvld & ~r_aw_done;
        s_wdat    = w_wdat;
        s_wvld    = w_wvld & ~r_w_done;
        w_m_awrdy = s_awrdy & ~r_aw_done;
        w_m_wrdy  = s_wrdy & ~r_w_done;
      end
      WRESP: begin
        s_brdy    = w_brdy;
        w_m_bvld  = s_bvld;
        w_m_bresp = s_bresp;
      end
      RADDR: begin
        s_aradr   = w_aradr;
        s_arvld   = w_arvld;
        w_m_arrdy = s_arrdy;
      end
      RDATA: begin
        s_rrdy   = w_rrdy;
        w_m_rvld = s_rvld;
        w_m_rdat = s_rdat;
      end
`ifdef ARB_TIMEOUT_EN
      ERESP: begin
        if (r_is_wr) begin
          w_m_bvld  = 1'b1;
          w_m_bresp = 2'b10;
        end else begin
          w_m_rvld = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign m0_awrdy = w_m_awrdy & ~w_sel;
  assign m0_wrdy  = w_m_wrdy  & ~w_sel;
  assign m0_bvld  = w_m_bvld  & ~w_sel;
  assign m0_bresp = w_sel ? 2'b00 : w_m_bresp;
  assign m0_arrdy = w_m_arrdy & ~w_sel;
  assign m0_rvld  = w_m_rvld  & ~w_sel;
  assign m0_rdat  = w_sel ? 32'd0 : w_m_rdat;
  assign m1_awrdy = w_m_awrdy & w_sel;
  assign m1_wrdy  = w_m_wrdy  & w_sel;
  assign m1_bvld  = w_m_bvld  & w_sel;
  assign m1_bresp = w_sel ? w_m_bresp : 2'b00;
  assign m1_arrdy = w_m_arrdy & w_sel;
  assign m1_rvld  = w_m_rvld  & w_sel;
  assign m1_rdat  = w_sel ? w_m_rdat : 32'd0;

  assign w_aw_hs = s_awvld & s_awrdy;
  assign w_w_hs  = s_wvld & s_wrdy;
  assign w_fin   = ((r_state == WRESP) & s_bvld & w_brdy) |
                   ((r_state == RDATA) & s_rvld & w_rrdy);

  assign gnt = r_gnt;
`ifdef ARB_TIMEOUT_EN
  assign tout_err = r_tout_err;
`else
  assign tout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_last    <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_is_wr    <= 1'b0;
      r_tout_err <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_tout_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_req0 | w_req1) begin
            r_gnt     <= w_pick ? 2'b10 : 2'b01;
            r_state   <= w_pick_wr ? WADDR : RADDR;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_is_wr <= w_pick_wr;
`endif
          end
        end
        WADDR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) r_state <= WRESP;
        end
        RADDR: begin
          if (s_arvld && s_arrdy) r_state <= RDATA;
        end
        WRESP, RDATA: begin
          if (w_fin) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= w_sel;
          end
        end
`ifdef ARB_TIMEOUT_EN
        ERESP: begin
          if ((r_is_wr && w_brdy) || (!r_is_wr && w_rrdy)) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= w_sel;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
`ifdef ARB_TIMEOUT_EN
      // Abort overrides any same-cycle state move except a completing response.
      if (r_state != IDLE && r_state != ERESP && !w_fin) begin
        if (r_cnt == 8'(TOUT - 1)) begin
          r_state    <= ERESP;
          r_tout_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Directed bench for axil_arbiter_2to1: single read/write, contention, write-before-read, reset, timeout.
module tb_axil_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  m0_awadr, m1_awadr, m0_aradr, m1_aradr, s_awadr, s_aradr;
  logic        m0_awvld, m0_awrdy, m0_wvld, m0_wrdy, m0_bvld, m0_brdy;
  logic        m0_arvld, m0_arrdy, m0_rvld, m0_rrdy;
  logic        m1_awvld, m1_awrdy, m1_wvld, m1_wrdy, m1_bvld, m1_brdy;
  logic        m1_arvld, m1_arrdy, m1_rvld, m1_rrdy;
  logic [31:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
  logic [1:0]  m0_bresp, m1_bresp, s_bresp, gnt;
  logic        s_awvld, s_awrdy, s_wvld, s_wrdy, s_bvld, s_brdy;
  logic        s_arvld, s_arrdy, s_rvld, s_rrdy, tout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_arbiter_2to1 dut (
    .clk(clk), .rst(rst),
    .m0_awadr(m0_awadr), .m0_awvld(m0_awvld), .m0_awrdy(m0_awrdy),
    .m0_wdat(m0_wdat), .m0_wvld(m0_wvld), .m0_wrdy(m0_wrdy),
    .m0_bresp(m0_bresp), .m0_bvld(m0_bvld), .m0_brdy(m0_brdy),
    .m0_aradr(m0_aradr), .m0_arvld(m0_arvld), .m0_arrdy(m0_arrdy),
    .m0_rdat(m0_rdat), .m0_rvld(m0_rvld), .m0_rrdy(m0_rrdy),
    .m1_awadr(m1_awadr), .m1_awvld(m1_awvld), .m1_awrdy(m1_awrdy),
    .m1_wdat(m1_wdat), .m1_wvld(m1_wvld), .m1_wrdy(m1_wrdy),
    .m1_bresp(m1_bresp), .m1_bvld(m1_bvld), .m1_brdy(m1_brdy),
    .m1_aradr(m1_aradr), .m1_arvld(m1_arvld), .m1_arrdy(m1_arrdy),
    .m1_rdat(m1_rdat), .m1_rvld(m1_rvld), .m1_rrdy(m1_rrdy),
    .s_awadr(s_awadr), .s_awvld(s_awvld), .s_awrdy(s_awrdy),
    .s_wdat(s_wdat), .s_wvld(s_wvld), .s_wrdy(s_wrdy),
    .s_bresp(s_bresp), .s_bvld(s_bvld), .s_brdy(s_brdy),
    .s_aradr(s_aradr), .s_arvld(s_arvld), .s_arrdy(s_arrdy),
    .s_rdat(s_rdat), .s_rvld(s_rvld), .s_rrdy(s_rrdy),
    .gnt(gnt), .tout_err(tout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    rst = 1'b1;
    {m0_awadr, m1_awadr, m0_aradr, m1_aradr} = '0;
    {m0_awvld, m0_wvld, m0_brdy, m0_arvld, m0_rrdy} = '0;
    {m1_awvld, m1_wvld, m1_brdy, m1_arvld, m1_rrdy} = '0;
    {m0_wdat, m1_wdat, s_rdat} = '0;
    s_bresp = '0;
    {s_awrdy, s_wrdy, s_bvld, s_arrdy, s_rvld} = '0;

    // Reset
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_tout", tout_err, 0);
    chk("rst_s_awvld", s_awvld, 0);
    chk("rst_s_arvld", s_arvld, 0);
    chk("rst_m0_bvld", m0_bvld, 0);
    rst = 1'b0;

    // Single read from m0
    m0_arvld = 1; m0_aradr = 4'h8;
    tick();
    chk("rd_gnt", gnt, 2'b01);
    chk("rd_s_aradr", s_aradr, 4'h8);
    chk("rd_s_arvld", s_arvld, 1);
    s_arrdy = 1; #1;
    chk("rd_m0_arrdy", m0_arrdy, 1);
    chk("rd_m1_arrdy", m1_arrdy, 0);
    tick();
    m0_arvld = 0; s_arrdy = 0; s_rvld = 1; s_rdat = 32'h9; m0_rrdy = 1; #1;
    chk("rd_m0_rvld", m0_rvld, 1);
    chk("rd_m0_rdat", m0_rdat, 32'h9);
    chk("rd_m1_rdat", m1_rdat, 0);
    chk("rd_s_rrdy", s_rrdy, 1);
    chk("rd_s_arvld_off", s_arvld, 0);
    tick();
    s_rvld = 0; s_rdat = 0; m0_rrdy = 0; #1;
    chk("rd_idle_gnt", gnt, 0);
    chk("rd_idle_rrdy", s_rrdy, 0);

    // Single write from m1, slave takes W two cycles after AW
    m1_awvld = 1; m1_awadr = 4'h4; m1_wvld = 1; m1_wdat = 32'h41;
    tick();
    s_awrdy = 1; #1;
    chk("wr_gnt", gnt, 2'b10);
    chk("wr_s_awadr", s_awadr, 4'h4);
    chk("wr_s_awvld", s_awvld, 1);
    chk("wr_s_wdat", s_wdat, 32'h41);
    chk("wr_m1_awrdy", m1_awrdy, 1);
    chk("wr_m1_wrdy0", m1_wrdy, 0);
    chk("wr_m0_awrdy", m0_awrdy, 0);
    tick();
    m1_awvld = 0; s_awrdy = 0; #1;
    chk("wr_aw_gated", s_awvld, 0);
    chk("wr_s_wvld", s_wvld, 1);
    tick();
    s_wrdy = 1; #1;
    chk("wr_m1_wrdy1", m1_wrdy, 1);
    tick();
    m1_wvld = 0; s_wrdy = 0; s_bvld = 1; s_bresp = 2'b00; m1_brdy = 1; #1;
    chk("wr_m1_bvld", m1_bvld, 1);
    chk("wr_m1_bresp", m1_bresp, 2'b00);
    chk("wr_s_brdy", s_brdy, 1);
    chk("wr_m0_bvld", m0_bvld, 0);
    tick();
    s_bvld = 0; m1_brdy = 0; #1;
    chk("wr_idle_gnt", gnt, 0);

    // Contention: both read continuously, grants alternate starting with m0
    m0_arvld = 1; m0_aradr = 4'h0; m1_arvld = 1; m1_aradr = 4'h8;
    s_arrdy = 1; s_rvld = 1; s_rdat = 32'h5A; m0_rrdy = 1; m1_rrdy = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_s_aradr", s_aradr, (i % 2 == 0) ? 4'h0 : 4'h8);
      tick();
      tick();
      chk("rr_dead_gnt", gnt, 0);
    end
    m0_arvld = 0; m1_arvld = 0; s_arrdy = 0; s_rvld = 0; s_rdat = 0;
    m0_rrdy = 0; m1_rrdy = 0;

    // m0 issues write and read together: write first, then read
    m0_awvld = 1; m0_awadr = 4'h4; m0_wvld = 1; m0_wdat = 32'h77;
    m0_arvld = 1; m0_aradr = 4'h8;
    tick();
    s_awrdy = 1; s_wrdy = 1; #1;
    chk("wa_gnt", gnt, 2'b01);
    chk("wa_s_awvld", s_awvld, 1);
    chk("wa_s_arvld", s_arvld, 0);
    tick();
    m0_awvld = 0; m0_wvld = 0; s_awrdy = 0; s_wrdy = 0;
    s_bvld = 1; s_bresp = 2'b01; m0_brdy = 1; #1;
    chk("wa_m0_bresp", m0_bresp, 2'b01);
    chk("wa_m1_bresp", m1_bresp, 0);
    tick();
    s_bvld = 0; s_bresp = 0; m0_brdy = 0; #1;
    chk("wa_dead_gnt", gnt, 0);
    tick();
    chk("wa_rd_gnt", gnt, 2'b01);
    chk("wa_rd_s_arvld", s_arvld, 1);
    chk("wa_rd_s_aradr", s_aradr, 4'h8);

    // Reset while in RDATA
    s_arrdy = 1;
    tick();
    m0_arvld = 0; s_arrdy = 0; s_rvld = 1; s_rdat = 32'h33; #1;
    chk("rs_rdata_rvld", m0_rvld, 1);
    rst = 1;
    tick();
    rst = 0; m0_rrdy = 1; #1;
    chk("rs_gnt", gnt, 0);
    chk("rs_s_rrdy", s_rrdy, 0);
    chk("rs_m0_rvld", m0_rvld, 0);
    s_rvld = 0; s_rdat = 0; m0_rrdy = 0;
    m0_arvld = 1; m1_arvld = 1;
    tick();
    chk("rs_tie_gnt", gnt, 2'b01);
    m0_arvld = 0; m1_arvld = 0;
    rst = 1; tick(); rst = 0;

    // Request withdrawn before the sampling edge: no grant
    m1_arvld = 1; #2; m1_arvld = 0;
    tick();
    chk("wd_gnt", gnt, 0);

`ifdef ARB_TIMEOUT_EN
    // Hung write: slave never answers B, abort after 64 cycles
    m0_awvld = 1; m0_awadr = 4'h4; m0_wvld = 1; m0_wdat = 32'h1;
    tick();
    s_awrdy = 1; s_wrdy = 1;
    for (int i = 1; i < 64; i++) begin
      tick();
      m0_awvld = 0; m0_wvld = 0; s_awrdy = 0; s_wrdy = 0;
    end
    #1;
    chk("to_pre", tout_err, 0);
    chk("to_pre_gnt", gnt, 2'b01);
    tick();
    chk("to_err", tout_err, 1);
    chk("to_bvld", m0_bvld, 1);
    chk("to_bresp", m0_bresp, 2'b10);
    chk("to_s_brdy", s_brdy, 0);
    tick();
    chk("to_pulse", tout_err, 0);
    chk("to_hold", m0_bvld, 1);
    m0_brdy = 1;
    tick();
    m0_brdy = 0; #1;
    chk("to_idle_gnt", gnt, 0);
    chk("to_idle_bvld", m0_bvld, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
